fp_div: RTL
===========

# fp_div

Iterative half-precision (default E5M10) floating-point divider: the inverse operator to the team's `fpMul`, used by the CNN datapath for normalisation and averaging (result = flp_a / flp_b). It uses a radix-2 restoring mantissa divider driven by a small FSM, one quotient bit per cycle. Operands and results travel on valid/ready handshakes; the block sits beside `fpMul` in the arithmetic layer.

## Interface
- EXPONENT_WIDTH, 5, exponent field width E; bias = 2^(E-1)-1.
- MANTISSA_WIDTH, 10, stored fraction width M; word width W = E+M+1.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; **one clock; reset is synchronous and active-low**.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept; high only in IDLE.
- flp_a  in  W  dividend {sign, exponent, fraction}.
- flp_b  in  W  divisor.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts result.
- result  out  W  quotient.
- div_by_zero  out  1  finite nonzero / zero.
- overflow  out  1  result saturated to infinity.
- underflow  out  1  result flushed to zero.
- invalid  out  1  NaN produced.

## Operation
- FSM states: IDLE -> DIV -> NORM -> DONE -> IDLE.
- IDLE: `in_ready`=1. On in_valid & in_ready, latch the operands, the sign (a^b) and the exponent difference, then go to DIV.
- DIV runs M+3 iterations on 11-bit significands {1,frac}. The partial remainder is M+3 bits, and each step shifts in one quotient bit. Q = floor(ma·2^(M+2)/mb) is M+3 bits wide; sticky = remainder≠0.
- NORM normalises and rounds:
  - If Q[M+2]=1: fraction=Q[M+1:2], guard=Q[1], sticky|=Q[0], exp=ea−eb+bias.
  - Otherwise: fraction=Q[M:1], guard=Q[0], exp=ea−eb+bias−1.
  - The exponent is computed signed, E+2 bits.
- Rounding: truncate by default (see Configuration). A rounding carry out of the fraction increments exp and clears the fraction.
- Range:
  - exp ≥ 2^E−1 -> ±inf, overflow=1.
  - exp ≤ 0 -> ±0, underflow=1. No subnormal outputs.
- Special inputs are resolved at acceptance, but the fixed latency is kept:
  - exp=0 counts as zero (subnormal inputs are flushed).
  - exp all-ones with frac≠0 is NaN.
  - NaN operand, 0/0 or inf/inf -> 0x7E00 (canonical NaN, sign 0), invalid=1.
  - inf/finite -> ±inf.
  - finite/inf -> ±0, no flag.
  - x/0 with x finite nonzero -> ±inf, div_by_zero=1.
  - 0/finite nonzero -> ±0.
- DONE: `out_valid`=1. `result` and all flags are stable until out_valid & out_ready, then the FSM returns to IDLE. No new operand is accepted in that same cycle.

## Timing
- Reset (rst_n low at an edge): state=IDLE, out_valid=0, result=0, all flags=0, iteration counter=0. in_ready=1 from the first edge with rst_n high onward.
- A reset while in DIV, NORM or DONE aborts the division and discards the result.
- Latency: with the accepting edge as edge 0, out_valid rises after edge M+4 (14 edges for the defaults). The latency is identical for special cases.
- Throughput: at most one division per M+6 cycles when out_ready is held high.
- in_valid is ignored outside IDLE. Operands need only be valid on the accepting edge.
- Flags are mutually exclusive and valid only with out_valid. They read 0 otherwise.

## Configuration
- `FP_DIV_RNE_EN` defined: round-to-nearest-even. Increment when guard & (sticky | fraction[0]).
- Undefined: truncation, so guard and sticky are ignored. Latency is unchanged either way.

## Structure
- `fp_div_pkg` contains:
  - the state enum, which must be 2 bits;
  - the bias, NaN and infinity constants, as functions of E and M;
  - a unpack helper returning sign/exp/frac/is_zero/is_inf/is_nan.
- Sub-module `fp_div_round`: combinational normalisation, rounding and range check. Input {sign, Q, sticky, exp}; output {result, overflow, underflow}. It is registered in NORM.
- Top level: FSM, iteration counter, divider datapath, handshake.

## Test plan
- 0x4500 / 0x4200 (5/3) -> 0x3EAA without macro, 0x3EAB with `FP_DIV_RNE_EN`; out_valid exactly 14 edges after accept.
- 0x4B80 / 0x4200 (15/3) -> 0x4500; 0xC500 / 0x4500 -> 0xBC00; no flags.
- 0x3C00 / 0x0000 -> 0x7C00, div_by_zero=1; 0xBC00 / 0x0000 -> 0xFC00; 0x0000 / 0x0000 -> 0x7E00, invalid=1.
- 0x7BFF / 0x1400 -> 0x7C00, overflow=1; 0x0400 / 0x7BFF -> 0x0000, underflow=1.
- out_ready low for 5 cycles in DONE -> result and out_valid held, in_ready=0; in_valid asserted meanwhile is not accepted.
- rst_n low for one edge mid-DIV -> out_valid=0, result=0, in_ready=1 after the edge; the next operand pair completes with correct latency.

Source files
------------

// File: rtl/fp_div_pkg.sv
// Shared types, constants and operand unpacking for the half-precision divider.
// Field widths default to E5M10 and match the fp_div parameter defaults.
package fp_div_pkg;

   localparam int FP_E    = 5;
   localparam int FP_M    = 10;
   localparam int FP_W    = FP_E + FP_M + 1;
   localparam int FP_BIAS = (1 << (FP_E - 1)) - 1;

   localparam logic [FP_W-1:0] FP_INF = {1'b0, {FP_E{1'b1}}, {FP_M{1'b0}}};
   localparam logic [FP_W-1:0] FP_NAN = {1'b0, {FP_E{1'b1}}, 1'b1, {(FP_M-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

   typedef struct packed {
      logic            sign;
      logic [FP_E-1:0] exp;
      logic [FP_M-1:0] frac;
      logic            is_zero;
      logic            is_inf;
      logic            is_nan;
   } fp_fields_t;

   // Subnormal encodings classify as zero, since they are flushed on input.
   function automatic fp_fields_t fp_unpack(input logic [FP_W-1:0] word);
      fp_fields_t f;
      f.sign    = word[FP_W-1];
      f.exp     = word[FP_W-2:FP_M];
      f.frac    = word[FP_M-1:0];
      f.is_zero = (f.exp == '0);
      f.is_inf  = (&f.exp) && (f.frac == '0);
      f.is_nan  = (&f.exp) && (f.frac != '0);
      return f;
   endfunction

endpackage

// File: rtl/fp_div_round.sv
// Normalisation, rounding and range check of the raw quotient.
// FP_DIV_RNE_EN selects round-to-nearest-even; otherwise the quotient is truncated.
module fp_div_round
   import fp_div_pkg::*;
#(
   parameter int E = FP_E,
   parameter int M = FP_M
) (
   input  logic                sign,
   input  logic [M+2:0]        quo,
   input  logic                sticky,
   input  logic signed [E+1:0] exp_pre,
   output logic [E+M:0]        result,
   output logic                overflow,
   output logic                underflow
);

   localparam logic signed [E+1:0] EXP_MAX  = (E+2)'((1 << E) - 1);
   localparam logic signed [E+1:0] EXP_ZERO = '0;

   logic [M-1:0]        frac;
   logic                guard;
   logic                st;
   logic                inc;
   logic signed [E+1:0] exp_norm;
   logic signed [E+1:0] exp_rnd;
   logic [M:0]          frac_sum;

   // A quotient below 1.0 leaves its leading one one place lower.
   always_comb begin
      if (quo[M+2]) begin
         frac     = quo[M+1:2];
         guard    = quo[1];
         st       = sticky | quo[0];
         exp_norm = exp_pre;
      end else begin
         frac     = quo[M:1];
         guard    = quo[0];
         st       = sticky;
         exp_norm = exp_pre - $signed((E+2)'(1));
      end
   end

`ifdef FP_DIV_RNE_EN
   assign inc = guard & (st | frac[0]);
`else
   logic unused_round;
   assign inc          = 1'b0;
   assign unused_round = guard ^ st;
`endif

   assign frac_sum = {1'b0, frac} + (M+1)'(inc);
   assign exp_rnd  = exp_norm + $signed({{(E+1){1'b0}}, frac_sum[M]});

   always_comb begin
      overflow  = 1'b0;
      underflow = 1'b0;
      result    = {sign, exp_rnd[E-1:0], frac_sum[M-1:0]};
      if (exp_rnd >= EXP_MAX) begin
         overflow = 1'b1;
         result   = {sign, {E{1'b1}}, {M{1'b0}}};
      end else if (exp_rnd <= EXP_ZERO) begin
         underflow = 1'b1;
         result    = {sign, {(E+M){1'b0}}};
      end
   end

endmodule

// File: rtl/fp_div.sv
// Iterative floating-point divider, one restoring quotient bit per cycle, valid/ready on both sides.
// Define FP_DIV_RNE_EN for round-to-nearest-even instead of truncation.
module fp_div
   import fp_div_pkg::*;
#(
   parameter int EXPONENT_WIDTH = FP_E,
   parameter int MANTISSA_WIDTH = FP_M
) (
   input  logic                                    clk,
   input  logic                                    rst_n,
   input  logic                                    in_valid,
   output logic                                    in_ready,
   input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0]  flp_a,
   input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0]  flp_b,
   output logic                                    out_valid,
   input  logic                                    out_ready,
   output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0]  result,
   output logic                                    div_by_zero,
   output logic                                    overflow,
   output logic                                    underflow,
   output logic                                    invalid
);

   localparam int E  = EXPONENT_WIDTH;
   localparam int M  = MANTISSA_WIDTH;
   localparam int W  = E + M + 1;
   localparam int CW = $clog2(M + 3);
   localparam logic signed [E+1:0] BIAS_S    = (E+2)'((1 << (E - 1)) - 1);
   localparam logic [CW-1:0]       LAST_ITER = CW'(M + 2);

   state_t              state_reg, state_next;
   logic [CW-1:0]       count_reg;
   logic [M+2:0]        rem_reg;
   logic [M+2:0]        quo_reg;
   logic [M:0]          mb_reg;
   logic                sign_reg;
   logic signed [E+1:0] exp_reg;
   logic                special_reg;
   logic [W-1:0]        special_result_reg;
   logic                special_dz_reg, special_inv_reg;
   logic [W-1:0]        result_reg;
   logic                dz_reg, ovf_reg, udf_reg, inv_reg;

   fp_fields_t   fa, fb;
   logic         sign_q;
   logic         special_next, special_dz_next, special_inv_next;
   logic [W-1:0] special_result_next;
   logic         q_bit;
   logic [M+1:0] rem_diff;
   logic         sticky;
   logic [W-1:0] rnd_result;
   logic         rnd_ovf, rnd_udf;

   assign fa     = fp_unpack(flp_a);
   assign fb     = fp_unpack(flp_b);
   assign sign_q = fa.sign ^ fb.sign;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (in_valid) state_next = DIV;
         DIV:     if (count_reg == LAST_ITER) state_next = NORM;
         NORM:    state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Special operands are decided at acceptance; the divider still runs so latency stays fixed.
   always_comb begin
      special_next        = 1'b1;
      special_result_next = '0;
      special_dz_next     = 1'b0;
      special_inv_next    = 1'b0;
      if (fa.is_nan | fb.is_nan | (fa.is_zero & fb.is_zero) | (fa.is_inf & fb.is_inf)) begin
         special_result_next = FP_NAN;
         special_inv_next    = 1'b1;
      end else if (fa.is_inf) begin
         special_result_next = {sign_q, FP_INF[W-2:0]};
      end else if (fb.is_inf | fa.is_zero) begin
         special_result_next = {sign_q, {(W-1){1'b0}}};
      end else if (fb.is_zero) begin
         special_result_next = {sign_q, FP_INF[W-2:0]};
         special_dz_next     = 1'b1;
      end else begin
         special_next = 1'b0;
      end
   end

   assign q_bit    = rem_reg >= {2'b00, mb_reg};
   assign rem_diff = q_bit ? (M+2)'(rem_reg - {2'b00, mb_reg}) : (M+2)'(rem_reg);
   assign sticky   = rem_reg != '0;

   fp_div_round #(.E(E), .M(M)) u_round (
      .sign      (sign_reg),
      .quo       (quo_reg),
      .sticky    (sticky),
      .exp_pre   (exp_reg),
      .result    (rnd_result),
      .overflow  (rnd_ovf),
      .underflow (rnd_udf)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg          <= IDLE;
         count_reg          <= '0;
         rem_reg            <= '0;
         quo_reg            <= '0;
         mb_reg             <= '0;
         sign_reg           <= 1'b0;
         exp_reg            <= '0;
         special_reg        <= 1'b0;
         special_result_reg <= '0;
         special_dz_reg     <= 1'b0;
         special_inv_reg    <= 1'b0;
         result_reg         <= '0;
         dz_reg             <= 1'b0;
         ovf_reg            <= 1'b0;
         udf_reg            <= 1'b0;
         inv_reg            <= 1'b0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            IDLE: if (in_valid) begin
               rem_reg            <= {2'b00, 1'b1, fa.frac};
               mb_reg             <= {1'b1, fb.frac};
               quo_reg            <= '0;
               count_reg          <= '0;
               sign_reg           <= sign_q;
               exp_reg            <= $signed({2'b00, fa.exp}) - $signed({2'b00, fb.exp}) + BIAS_S;
               special_reg        <= special_next;
               special_result_reg <= special_result_next;
               special_dz_reg     <= special_dz_next;
               special_inv_reg    <= special_inv_next;
            end
            DIV: begin
               rem_reg   <= {rem_diff, 1'b0};
               quo_reg   <= {quo_reg[M+1:0], q_bit};
               count_reg <= count_reg + 1'b1;
            end
            NORM: begin
               result_reg <= special_reg ? special_result_reg : rnd_result;
               dz_reg     <= special_reg & special_dz_reg;
               inv_reg    <= special_reg & special_inv_reg;
               ovf_reg    <= ~special_reg & rnd_ovf;
               udf_reg    <= ~special_reg & rnd_udf;
            end
            DONE: if (out_ready) begin
               dz_reg  <= 1'b0;
               inv_reg <= 1'b0;
               ovf_reg <= 1'b0;
               udf_reg <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign in_ready    = (state_reg == IDLE);
   assign out_valid   = (state_reg == DONE);
   assign result      = result_reg;
   assign div_by_zero = dz_reg;
   assign overflow    = ovf_reg;
   assign underflow   = udf_reg;
   assign invalid     = inv_reg;

endmodule
